// File: rtl/button_array_interface_pkg.sv
// ---------------------------------------------------------------------------
// button_array_interface_pkg
//   Shared definitions for the push-button array: channel FSM state encoding,
//   default timing constants (12 MHz board clock) and a counter-width helper.
// ---------------------------------------------------------------------------
package button_array_interface_pkg;

  // Per-channel press-tracking states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // debounced level released
    ST_DOWN = 2'd1,   // pressed, counting towards long-press
    ST_LONG = 2'd2    // long-press reached, generating repeats
  } btn_state_e;

  // Default timing at 12 MHz
  localparam int DEF_N_BTN           = 4;
  localparam int DEF_ACTIVE_LOW      = 1;
  localparam int DEF_DEBOUNCE_CYCLES = 1_200_000;  // 100 ms
  localparam int DEF_LONG_CYCLES     = 12_000_000; // 1 s
  localparam int DEF_REPEAT_CYCLES   = 2_400_000;  // 200 ms
  localparam int DEF_REPEAT_EN       = 1;

  // Width of a counter that must reach cycles-1; never narrower than one bit
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/button_array_interface_channel.sv
// ---------------------------------------------------------------------------
// button_array_interface_channel
//   One button: 2-FF synchroniser, polarity normalisation, debounce counter
//   and the press/long/repeat FSM. All outputs are registers.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   btn_in          raw asynchronous pin level
//   btn_level       debounced level, 1 = pressed
//   press_tick      1-cycle pulse when btn_level rises
//   release_tick    1-cycle pulse when btn_level falls
//   long_tick       1-cycle pulse once per press after LONG_CYCLES held
//   repeat_tick     1-cycle pulse every REPEAT_CYCLES while long-pressed
// ---------------------------------------------------------------------------
module button_array_interface_channel
  import button_array_interface_pkg::*;
#(
  parameter int ACTIVE_LOW      = DEF_ACTIVE_LOW,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_tick,
  output logic release_tick,
  output logic long_tick,
  output logic repeat_tick
);

  localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_CYCLES);
  localparam int REP_W  = cnt_width(REPEAT_CYCLES);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  // Pin level that means "released"; also the XOR mask that makes pressed = 1
  localparam logic POL_BIT    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic REP_EN_BIT = (REPEAT_EN != 0) ? 1'b1 : 1'b0;

  logic              sync1_r;
  logic              sync2_r;
  logic [DEB_W-1:0]  deb_cnt_r;
  logic              level_r;
  logic              press_r;
  logic              release_r;

  btn_state_e        state_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [REP_W-1:0]  rep_cnt_r;
  logic              long_r;
  logic              repeat_r;

  logic              synced_s;
  logic              flip_s;
  logic              rise_s;
  logic              fall_s;
  logic [DEB_W-1:0]  deb_cnt_nxt_s;

  btn_state_e        state_nxt_s;
  logic [HOLD_W-1:0] hold_cnt_nxt_s;
  logic [REP_W-1:0]  rep_cnt_nxt_s;
  logic              long_nxt_s;
  logic              repeat_nxt_s;

  // Debounce decision: count consecutive cycles the synced level disagrees
  always_comb begin
    synced_s      = sync2_r ^ POL_BIT;
    flip_s        = 1'b0;
    deb_cnt_nxt_s = {DEB_W{1'b0}};
    if (synced_s != level_r) begin
      if (deb_cnt_r == DEB_LAST) begin
        flip_s        = 1'b1;
        deb_cnt_nxt_s = {DEB_W{1'b0}};
      end else begin
        flip_s        = 1'b0;
        deb_cnt_nxt_s = deb_cnt_r + DEB_W'(1);
      end
    end else begin
      flip_s        = 1'b0;
      deb_cnt_nxt_s = {DEB_W{1'b0}};
    end
    rise_s = flip_s & ~level_r;
    fall_s = flip_s & level_r;
  end

  // Synchroniser, debounced level and press/release pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r   <= POL_BIT;
      sync2_r   <= POL_BIT;
      deb_cnt_r <= {DEB_W{1'b0}};
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      sync1_r   <= btn_in;
      sync2_r   <= sync1_r;
      deb_cnt_r <= deb_cnt_nxt_s;
      level_r   <= level_r ^ flip_s;
      press_r   <= rise_s;
      release_r <= fall_s;
    end
  end

  // Channel FSM next state; a release on the terminal-count cycle suppresses
  // the long/repeat pulse because the release branch is tested first
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    rep_cnt_nxt_s  = rep_cnt_r;
    long_nxt_s     = 1'b0;
    repeat_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        hold_cnt_nxt_s = {HOLD_W{1'b0}};
        rep_cnt_nxt_s  = {REP_W{1'b0}};
        if (rise_s) begin
          state_nxt_s = ST_DOWN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DOWN: begin
        if (fall_s) begin
          state_nxt_s    = ST_IDLE;
          hold_cnt_nxt_s = {HOLD_W{1'b0}};
          rep_cnt_nxt_s  = {REP_W{1'b0}};
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_nxt_s    = ST_LONG;
          hold_cnt_nxt_s = {HOLD_W{1'b0}};
          rep_cnt_nxt_s  = {REP_W{1'b0}};
          long_nxt_s     = 1'b1;
        end else begin
          state_nxt_s    = ST_DOWN;
          hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
        end
      end
      ST_LONG: begin
        if (fall_s) begin
          state_nxt_s    = ST_IDLE;
          hold_cnt_nxt_s = {HOLD_W{1'b0}};
          rep_cnt_nxt_s  = {REP_W{1'b0}};
        end else if (rep_cnt_r == REP_LAST) begin
          state_nxt_s   = ST_LONG;
          rep_cnt_nxt_s = {REP_W{1'b0}};
          repeat_nxt_s  = REP_EN_BIT;
        end else begin
          state_nxt_s   = ST_LONG;
          rep_cnt_nxt_s = rep_cnt_r + REP_W'(1);
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        hold_cnt_nxt_s = {HOLD_W{1'b0}};
        rep_cnt_nxt_s  = {REP_W{1'b0}};
      end
    endcase
  end

  // Channel FSM state, counters and long/repeat pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= {HOLD_W{1'b0}};
      rep_cnt_r  <= {REP_W{1'b0}};
      long_r     <= 1'b0;
      repeat_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      rep_cnt_r  <= rep_cnt_nxt_s;
      long_r     <= long_nxt_s;
      repeat_r   <= repeat_nxt_s;
    end
  end

  assign btn_level    = level_r;
  assign press_tick   = press_r;
  assign release_tick = release_r;
  assign long_tick    = long_r;
  assign repeat_tick  = repeat_r;

endmodule

// File: rtl/button_array_interface.sv
// ---------------------------------------------------------------------------
// button_array_interface
//   N independent push-button channels: synchronise, debounce, and emit
//   press / release / long-press / auto-repeat one-clock pulses.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   btn_in          [N_BTN] raw pin levels
//   btn_level       [N_BTN] debounced level, 1 = pressed
//   press_tick      [N_BTN] pulse on debounced press
//   release_tick    [N_BTN] pulse on debounced release
//   long_tick       [N_BTN] pulse once per press after LONG_CYCLES held
//   repeat_tick     [N_BTN] pulse every REPEAT_CYCLES while long-pressed
// Timing parameters must all be >= 2.
// ---------------------------------------------------------------------------
module button_array_interface
  import button_array_interface_pkg::*;
#(
  parameter int N_BTN           = DEF_N_BTN,
  parameter int ACTIVE_LOW      = DEF_ACTIVE_LOW,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_tick,
  output logic [N_BTN-1:0] release_tick,
  output logic [N_BTN-1:0] long_tick,
  output logic [N_BTN-1:0] repeat_tick
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_array_interface_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (REPEAT_EN)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .btn_in       (btn_in[i]),
      .btn_level    (btn_level[i]),
      .press_tick   (press_tick[i]),
      .release_tick (release_tick[i]),
      .long_tick    (long_tick[i]),
      .repeat_tick  (repeat_tick[i])
    );
  end

endmodule

// File: tb/tb_button_array_interface.sv
module tb_button_array_interface;

  localparam int N    = 2;
  localparam int DEB  = 8;
  localparam int LONG = 32;
  localparam int REP  = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level, press_tick, release_tick, long_tick, repeat_tick;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  button_array_interface #(
    .N_BTN(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(btn_level), .press_tick(press_tick), .release_tick(release_tick),
    .long_tick(long_tick), .repeat_tick(repeat_tick)
  );

  // Reference model: history of pressed samples, level flips once the
  // 2-cycle-delayed input has disagreed for DEB samples; long/repeat from elapsed time
  logic         hist [N][DEB+2];
  logic         m_level [N];
  int           press_edge [N];
  logic [N-1:0] e_level, e_press, e_rel, e_long, e_rep;

  // Observed pulse bookkeeping for the directed timing checks
  int press_cnt [N], rel_cnt [N], long_cnt [N];
  int press_cyc [N], rel_cyc [N], long_cyc [N];
  int rep_q [$];

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      for (int i = 0; i < DEB + 2; i++) hist[c][i] = 1'b0;
      m_level[c]    = 1'b0;
      press_edge[c] = 0;
    end
    e_level = '0; e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] pins);
    bit all_diff;
    int el;
    for (int c = 0; c < N; c++) begin
      for (int i = 0; i < DEB + 1; i++) hist[c][i] = hist[c][i+1];
      hist[c][DEB+1] = ~pins[c];  // active-low pin
      all_diff = 1'b1;
      for (int i = 0; i < DEB; i++) if (hist[c][i] == m_level[c]) all_diff = 1'b0;
      e_press[c] = 1'b0; e_rel[c] = 1'b0; e_long[c] = 1'b0; e_rep[c] = 1'b0;
      if (all_diff) begin
        m_level[c] = ~m_level[c];
        e_press[c] = m_level[c];
        e_rel[c]   = ~m_level[c];
        if (m_level[c]) press_edge[c] = cyc;
      end else if (m_level[c]) begin
        el = cyc - press_edge[c];
        e_long[c] = (el == LONG);
        e_rep[c]  = (el > LONG) && (((el - LONG) % REP) == 0);
      end
      e_level[c] = m_level[c];
    end
  endtask

  task automatic step(input logic [N-1:0] pins);
    btn_in = pins;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) model_reset();
    else     model_edge(pins);
    chk("btn_level", btn_level, e_level);
    chk("press_tick", press_tick, e_press);
    chk("release_tick", release_tick, e_rel);
    chk("long_tick", long_tick, e_long);
    chk("repeat_tick", repeat_tick, e_rep);
    for (int c = 0; c < N; c++) begin
      if (press_tick[c])   begin press_cnt[c]++; press_cyc[c] = cyc; end
      if (release_tick[c]) begin rel_cnt[c]++;   rel_cyc[c]   = cyc; end
      if (long_tick[c])    begin long_cnt[c]++;  long_cyc[c]  = cyc; end
    end
    if (repeat_tick[0]) rep_q.push_back(cyc);
  endtask

  task automatic clear_counts();
    for (int c = 0; c < N; c++) begin
      press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0;
      press_cyc[c] = -1000; rel_cyc[c] = -1000; long_cyc[c] = -1000;
    end
    rep_q.delete();
  endtask

  initial begin
    int t_ref;
    int run_left [N];
    logic [N-1:0] rpins;

    rst    = 1'b1;
    btn_in = 2'b11;
    model_reset();
    clear_counts();
    #1;
    chk("reset_level", btn_level, 2'b00);
    chk("reset_ticks", press_tick | release_tick | long_tick | repeat_tick, 2'b00);
    repeat (3) step(2'b11);
    rst = 1'b0;
    repeat (5) step(2'b11);

    // 1: ch0 bounces in 3-cycle bursts, then held pressed
    for (int b = 0; b < 4; b++) begin
      repeat (3) step(2'b10);
      repeat (3) step(2'b11);
    end
    t_ref = cyc;
    repeat (15) step(2'b10);
    chk_int("t1_press_count", press_cnt[0], 1);
    chk_int("t1_press_latency", press_cyc[0] - t_ref, DEB + 2);
    chk("t1_level", btn_level, 2'b01);

    // 2: hold ch0 100 cycles after press
    while (cyc < press_cyc[0] + 100) step(2'b10);
    chk_int("t2_long_offset", long_cyc[0] - press_cyc[0], LONG);
    chk_int("t2_long_count", long_cnt[0], 1);
    chk_int("t2_rep_count", rep_q.size(), 6);
    if (rep_q.size() >= 3) begin
      chk_int("t2_rep1", rep_q[0] - long_cyc[0], REP);
      chk_int("t2_rep2", rep_q[1] - long_cyc[0], 2 * REP);
      chk_int("t2_rep3", rep_q[2] - long_cyc[0], 3 * REP);
    end

    // 3: release ch0 with 2-cycle bounce
    clear_counts();
    repeat (2) step(2'b11);
    repeat (2) step(2'b10);
    repeat (20) step(2'b11);
    t_ref = rep_q.size();
    repeat (40) step(2'b11);
    chk_int("t3_release_count", rel_cnt[0], 1);
    chk("t3_level", btn_level, 2'b00);
    chk_int("t3_no_rep_after", rep_q.size(), t_ref);
    chk_int("t3_no_press", press_cnt[0], 0);

    // 4: ch1 release lands on long terminal count
    clear_counts();
    repeat (12) step(2'b01);
    while (cyc < press_cyc[1] + LONG - DEB - 2) step(2'b01);
    repeat (30) step(2'b11);
    chk_int("t4_release_offset", rel_cyc[1] - press_cyc[1], LONG);
    chk_int("t4_release_count", rel_cnt[1], 1);
    chk_int("t4_no_long", long_cnt[1], 0);

    // 5: both pressed in the same cycle, then a 7-cycle glitch on ch1
    clear_counts();
    t_ref = cyc;
    repeat (12) step(2'b00);
    chk_int("t5_press0_at", press_cyc[0] - t_ref, DEB + 2);
    chk_int("t5_press1_at", press_cyc[1] - t_ref, DEB + 2);
    repeat (7) step(2'b10);
    repeat (40) step(2'b00);
    chk_int("t5_glitch_no_release", rel_cnt[1], 0);
    chk_int("t5_glitch_no_press", press_cnt[1], 1);
    chk_int("t5_long0", long_cnt[0], 1);

    // 6: reset pulse during long-press with pins still pressed
    clear_counts();
    #2 rst = 1'b1;
    #1;
    chk("t6_async_level", btn_level, 2'b00);
    chk("t6_async_ticks", press_tick | release_tick | long_tick | repeat_tick, 2'b00);
    model_reset();
    repeat (2) step(2'b00);
    rst = 1'b0;
    t_ref = cyc;
    repeat (15) step(2'b00);
    chk_int("t6_press0_at", press_cyc[0] - t_ref, DEB + 2);
    chk_int("t6_press1_at", press_cyc[1] - t_ref, DEB + 2);
    chk_int("t6_no_release0", rel_cnt[0], 0);
    chk_int("t6_no_release1", rel_cnt[1], 0);

    // Randomised run-length stimulus against the model
    for (int c = 0; c < N; c++) run_left[c] = 0;
    rpins = 2'b00;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++) begin
        if (run_left[c] == 0) begin
          rpins[c] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) run_left[c] = $urandom_range(30, 90);
          else                           run_left[c] = $urandom_range(1, 12);
        end
        run_left[c]--;
      end
      step(rpins);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
